// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, RX FIFO default depth and receiver state encodings.
// Receiver, RX FIFO and transmitter all take their common sizes from here.
package uart_pkg;

    localparam int unsigned UART_DATA_W           = 8;
    localparam int unsigned RX_FIFO_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        RxIdle  = 2'd0,
        RxStart = 2'd1,
        RxData  = 2'd2,
        RxStop  = 2'd3
    } rx_state_e;

    // Fill-level width able to represent 0..depth inclusive.
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead synchronous FIFO with fill level and sticky overflow flag.
// Head entry is visible on rd_data_o before it is popped.
module sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic              clr_overflow_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              wr_ok, rd_ok;

    // A write into a full FIFO still lands when the same cycle frees a slot.
    always_comb begin
        rd_ok      = rd_en_i & ~empty_q;
        wr_ok      = wr_en_i & (~full_q | rd_en_i);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        last_d     = last_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = mem_q[rd_ptr_q];
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);

        // Set has priority over clear so a drop in the clearing cycle is not lost.
        if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end
        if (wr_en_i && full_q && !rd_en_i) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // While empty, hold the most recently popped byte (zero after reset).
    always_comb begin
        rd_data_o = empty_q ? last_q : mem_q[rd_ptr_q];
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: captures one byte per rx_done rising edge into a show-ahead FIFO
// and reports fill level plus a sticky overflow error.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = RX_FIFO_DEPTH_DEFAULT,
    parameter int unsigned DATA_W = UART_DATA_W,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rd_en,
    input  logic              clr_overflow,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    logic done_q, done_d;
    logic wr_evt;

    always_comb begin
        done_d = rx_done;
        wr_evt = rx_done & ~done_q;
    end

    // Reset to 1 so an rx_done level held across reset release is not taken as a new byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b1;
        end else begin
            done_q <= done_d;
        end
    end

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i          (clock),
        .rst_ni         (reset_n),
        .wr_en_i        (wr_evt),
        .wr_data_i      (rx_data),
        .rd_en_i        (rd_en),
        .clr_overflow_i (clr_overflow),
        .rd_data_o      (rd_data),
        .full_o         (full),
        .empty_o        (empty),
        .count_o        (count),
        .overflow_o     (overflow)
    );

endmodule
